// File: rtl/spike_route_scheduler.sv
// spike_route_scheduler: serialises one timestep's spike deliveries onto a
// single accumulate port, one (source, target) pair per handshake.
// Optional build macro ROUND_ROBIN_SRC_EN rotates the starting source each
// step. Without it, pairs are issued lowest source first.
module spike_route_scheduler #(
  parameter int N_NODES = 4,
  parameter int IDX_W   = $clog2(N_NODES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_NODES-1:0]           spike_in,
  input  logic [N_NODES*N_NODES-1:0]   conn,
  input  logic                         step_start,
  output logic                         acc_valid,
  output logic [IDX_W-1:0]             acc_src,
  output logic [IDX_W-1:0]             acc_tgt,
  input  logic                         acc_ready,
  output logic                         busy,
  output logic                         step_done,
  output logic                         step_overrun
);

  localparam int NN   = N_NODES * N_NODES;
  localparam int NN_W = $clog2(NN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_NODES-1:0]  pending_q, pending_d;
  logic [NN-1:0]       work_q, work_d;
  logic                overrun_q, overrun_d;
  logic [NN-1:0]       load_mask;
  logic [IDX_W-1:0]    srch_base;

  logic                sel_hit;
  logic [IDX_W-1:0]    sel_src, sel_tgt;
  logic [NN-1:0]       sel_oh;
  logic [NN_W-1:0]     sel_idx;

  // Work mask at step start: spiked sources gated by the connection matrix.
  // Work is stored source-major (s*N+t) so the search order is a plain scan;
  // conn is target-major (t*N+s). Self-loops are never delivered.
  for (genvar s = 0; s < N_NODES; s++) begin : g_src
    for (genvar t = 0; t < N_NODES; t++) begin : g_tgt
      if (s == t) begin : g_self
        assign load_mask[s*N_NODES+t] = 1'b0;
      end else begin : g_pair
        assign load_mask[s*N_NODES+t] =
          (pending_q[s] | spike_in[s]) & conn[t*N_NODES+s];
      end
    end
  end

`ifdef ROUND_ROBIN_SRC_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Priority pointer advances once per finished step, wrapping at N_NODES.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_DONE)
      rr_ptr_d = (rr_ptr_q == IDX_W'(N_NODES-1)) ? '0 : rr_ptr_q + 1'b1;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign srch_base = rr_ptr_q;
`else
  assign srch_base = '0;
`endif

  // Pick the first outstanding pair, scanning sources from srch_base with
  // wrap-around and targets ascending within each source.
  always_comb begin
    sel_hit = 1'b0;
    sel_src = '0;
    sel_tgt = '0;
    sel_oh  = '0;
    sel_idx = '0;
    for (int off = 0; off < N_NODES; off++) begin
      for (int t = 0; t < N_NODES; t++) begin
        sel_idx = NN_W'(((int'(srch_base) + off) % N_NODES) * N_NODES + t);
        if (!sel_hit && work_q[sel_idx]) begin
          sel_hit         = 1'b1;
          sel_src         = IDX_W'((int'(srch_base) + off) % N_NODES);
          sel_tgt         = IDX_W'(t);
          sel_oh[sel_idx] = 1'b1;
        end
      end
    end
  end

  // Next-state: step sequencing, spike pending capture, overrun flag.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    pending_d = pending_q | spike_in;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          work_d    = load_mask;
          pending_d = '0;          // this cycle's spikes are folded into work
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (step_start) overrun_d = 1'b1;
        if (!sel_hit)       state_d = S_DONE;
        else if (acc_ready) work_d  = work_q & ~sel_oh;
      end
      S_DONE: begin
        if (step_start) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy         = (state_q == S_ISSUE);
  assign step_done    = (state_q == S_DONE);
  assign acc_valid    = busy & sel_hit;
  assign acc_src      = acc_valid ? sel_src : '0;
  assign acc_tgt      = acc_valid ? sel_tgt : '0;
  assign step_overrun = overrun_q;

endmodule

// File: tb/tb_spike_route_scheduler.sv
// Randomised scoreboard bench for spike_route_scheduler (N_NODES=4).
// The driver computes the expected delivery list for each step from the
// spiked-source set and the conn snapshot; a monitor compares every
// presented command against the head of that list.
module tb_spike_route_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   spike_in = '0;
  logic [N*N-1:0] conn = '0;
  logic           step_start = 1'b0;
  logic           acc_ready = 1'b0;
  logic           acc_valid;
  logic [IW-1:0]  acc_src, acc_tgt;
  logic           busy, step_done, step_overrun;

  int checks = 0;
  int errors = 0;

  // reference model state
  int           exp_q[$];
  logic [N-1:0] m_pending = '0;
  bit           m_idle = 1'b1;
  bit           m_overrun = 1'b0;
  int           m_rr = 0;
  int           step_pairs = 0;
  int           start_cyc = 0;
  int           last_acc_cyc = -1;
  int           ready_mode = 0;
  int           cyc = 0;

  spike_route_scheduler #(.N_NODES(N)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .conn(conn),
    .step_start(step_start), .acc_valid(acc_valid), .acc_src(acc_src),
    .acc_tgt(acc_tgt), .acc_ready(acc_ready), .busy(busy),
    .step_done(step_done), .step_overrun(step_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected deliveries: every spiked source (in priority order) to every
  // connected target other than itself, targets ascending.
  task automatic push_pairs(input logic [N-1:0] act);
    step_pairs = 0;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_rr + k) % N;
      for (int t = 0; t < N; t++)
        if (act[s] && conn[t*N+s] && s != t) begin
          exp_q.push_back(s*16 + t);
          step_pairs++;
        end
    end
  endtask

  // One clock period of stimulus; model updated alongside.
  task automatic tick(input logic [N-1:0] spk, input bit start);
    if (start && m_idle) begin
      push_pairs(m_pending | spk);
      m_pending = '0;
      m_idle    = 1'b0;
      start_cyc = cyc;
    end else begin
      if (start) m_overrun = 1'b1;
      m_pending = m_pending | spk;
    end
    spike_in   = spk;
    step_start = start;
    case (ready_mode)
      0:       acc_ready = ($urandom_range(0, 3) != 0);
      1:       acc_ready = 1'b1;
      2:       acc_ready = ((cyc - start_cyc) >= 4);
      default: acc_ready = 1'b0;
    endcase
    @(posedge clk); #1;
    spike_in   = '0;
    step_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (step_done) begin
        seen = 1'b1;
        check("done_cycle", cyc, (step_pairs > 0) ? last_acc_cyc + 2 : start_cyc + 2);
        check("queue_drained", exp_q.size(), 0);
        check("overrun_flag", step_overrun, m_overrun);
`ifdef ROUND_ROBIN_SRC_EN
        m_rr = (m_rr + 1) % N;
`endif
        tick(rnd ? N'($urandom) : '0, 1'b0);
        m_idle = 1'b1;
      end else begin
        check("busy_in_step", busy, 1);
        if (rnd) conn = (N*N)'($urandom);   // must not affect the running step
        tick(rnd ? N'($urandom) : '0, rnd && ($urandom_range(0, 7) == 0));
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL step_done_timeout actual=none expected=pulse within %0d cycles", limit);
      exp_q.delete();
      m_idle = 1'b1;
    end
  endtask

  task automatic run_step(input logic [N-1:0] spk, input logic [N*N-1:0] c,
                          input int mode, input bit rnd);
    conn       = c;
    ready_mode = mode;
    tick(spk, 1'b1);
    wait_done(300, rnd);
  endtask

  // Monitor: every presented command must match the scoreboard head.
  initial begin
    bit prev_stall;
    logic [IW-1:0] prev_src, prev_tgt;
    prev_stall = 1'b0;
    prev_src = '0;
    prev_tgt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", acc_valid, 1);
          check("hold_src", acc_src, prev_src);
          check("hold_tgt", acc_tgt, prev_tgt);
        end
        if (acc_valid) begin
          check("valid_only_busy", busy, 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd actual=src%0d/tgt%0d expected=no command", acc_src, acc_tgt);
          end else begin
            check("cmd_pair", int'(acc_src)*16 + int'(acc_tgt), exp_q[0]);
            if (acc_ready) begin
              void'(exp_q.pop_front());
              last_acc_cyc = cyc;
            end
          end
        end
        if (step_done) check("done_not_busy", busy, 0);
        prev_stall = acc_valid & !acc_ready;
        prev_src   = acc_src;
        prev_tgt   = acc_tgt;
      end
    end
  end

  initial begin
    #2;
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_src", acc_src, 0);
    check("rst_acc_tgt", acc_tgt, 0);
    check("rst_busy", busy, 0);
    check("rst_step_done", step_done, 0);
    check("rst_overrun", step_overrun, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // source 0 to all others, always ready
    run_step(4'b0001, 16'hFFFF, 1, 1'b0);
    // backpressure: single pair s2->t0 held until ready rises
    run_step(4'b0100, 16'h0004, 2, 1'b0);
    // empty step
    run_step(4'b0000, 16'hFFFF, 1, 1'b0);

    // overrun during ISSUE, spike from source 3 carried to next step
    conn = 16'hFFFF;
    ready_mode = 1;
    tick(4'b0001, 1'b1);
    tick(4'b1000, 1'b1);
    wait_done(100, 1'b0);
    check("overrun_sticky", step_overrun, 1);
    run_step(4'b0000, 16'hFFFF, 1, 1'b0);

    // reset mid-ISSUE with the accumulator stalled
    conn = 16'hFFFF;
    ready_mode = 3;
    tick(4'b0010, 1'b1);
    tick(4'b0000, 1'b0);
    check("pre_rst_valid", acc_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", acc_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", step_done, 0);
    check("midrst_overrun", step_overrun, 0);
    exp_q.delete();
    m_pending = '0; m_idle = 1'b1; m_overrun = 1'b0; m_rr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_step(4'b0000, 16'hFFFF, 1, 1'b0);

    // same spike set twice: start source rotates when round robin is built in
    run_step(4'b0011, 16'hFFFF, 1, 1'b0);
    run_step(4'b0011, 16'hFFFF, 1, 1'b0);

    // randomised steps with idle gaps, backpressure and stray step_starts
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      ready_mode = 0;
      for (int g = 0; g < gap; g++) tick(N'($urandom), 1'b0);
      run_step(N'($urandom), (N*N)'($urandom), 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spike_route_scheduler.md
Name: spike_route_scheduler

Overview:
- Sequences spike deliveries for the neuron matrix onto one shared accumulate port, so each target adder receives one weighted input per handshake instead of multi-input adds.
- Latches sources that spiked during a timestep and masks them with the N x N connection matrix.
- Issues one (source, target) pair at a time until every connected pair is delivered, then pulses step_done.
- Sits between the spike-generating Izhikevich cores and the per-neuron accumulator/adder bank.

Parameters:
N_NODES, 4, number of neurons (sources = targets); legal 2..16
IDX_W, $clog2(N_NODES), width of source/target index outputs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
spike_in  input  N_NODES  per-source spike pulses, sampled every cycle
conn  input  N_NODES*N_NODES  adjacency; bit t*N_NODES+s = source s drives target t
step_start  input  1  single-cycle pulse: begin delivering the current timestep
acc_valid  output  1  accumulate command valid
acc_src  output  IDX_W  source index of current command
acc_tgt  output  IDX_W  target index of current command
acc_ready  input  1  accumulator accepts the command
busy  output  1  high from the cycle after an accepted step_start until step_done
step_done  output  1  single-cycle pulse: timestep fully delivered
step_overrun  output  1  sticky: step_start arrived while busy

Behaviour:
- Reset (async, rst_n=0): state=IDLE. acc_valid=0, acc_src=0, acc_tgt=0, busy=0, step_done=0, step_overrun=0. Pending and work masks cleared. Takes effect immediately, including mid-step; the in-flight command is dropped and not replayed.
- pending[N]: every cycle, pending |= spike_in.
- FSM IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - step_start=1 at cycle 0 loads work[s*N+t] = (pending[s] | spike_in[s]) & conn[t*N+s] & (s!=t). Self-connections are never issued.
  - Clears pending in the same edge; spike_in in that cycle is consumed, not re-pended.
  - Enters ISSUE; busy=1 from cycle 1.
- ISSUE:
  - Selected pair = lowest set index of work (source-major, target-minor); no idle cycles between pairs.
  - If work≠0: acc_valid=1 from cycle 1; acc_src/acc_tgt show the selected pair.
  - Command held stable while acc_valid & !acc_ready.
  - On acc_valid & acc_ready, that work bit clears; next pair presented the following cycle.
  - When work==0 (including empty at entry), go to DONE next edge; acc_valid=0 in that cycle.
- DONE: step_done=1 for exactly one cycle, busy=0 that cycle; return to IDLE.
  - Empty step: step_start at cycle 0 gives step_done at cycle 2.
- conn is sampled only at step_start; later changes do not affect the step in progress.
- step_start while not IDLE: ignored, step_overrun set (cleared only by reset); pending unaffected.
- spike_in during ISSUE/DONE accumulates in pending for the next step. A repeated spike of the same source before the next step_start is merged (delivered once).
- acc_valid never asserts outside ISSUE.

Optional Feature:
- Macro ROUND_ROBIN_SRC_EN.
- Defined:
  - A rotating source pointer rr_ptr (reset 0) sets priority; search starts at source rr_ptr and wraps modulo N_NODES, targets still ascending within a source.
  - rr_ptr increments by 1 (wraps N_NODES-1 -> 0) at each step_done.
- Undefined: fixed lowest-index-first order; no pointer register.

Test Plan:
1. Reset mid-ISSUE (N=4, src1 spiked, conn all ones): assert rst_n=0 while acc_valid=1 -> acc_valid/busy drop in the same cycle; no step_done; next step delivers nothing unless new spikes arrive.
2. spike_in=4'b0001 then step_start, conn all ones, acc_ready=1 -> pairs (0,1),(0,2),(0,3) on consecutive cycles 1-3; (0,0) skipped; step_done at cycle 5.
3. Backpressure: spike_in=4'b0100, conn only t0<-s2; acc_ready low for 3 cycles -> acc_valid=1, acc_src=2, acc_tgt=0 held stable 4 cycles; single transfer; step_done 2 cycles after accept.
4. Empty step: no spikes, step_start -> acc_valid never 1; step_done exactly at cycle 2; busy=1 only at cycle 1.
5. Overrun/pending: step_start during ISSUE plus spike_in=4'b1000 -> step_overrun=1; after step_done, next step_start delivers source 3's connected pairs.
6. ROUND_ROBIN_SRC_EN: spikes 4'b0011, conn all ones, two steps -> step 1 begins with src 0, step 2 (same spikes) begins with src 1.
